decoder_3to8_reg: RTL and testbench
===================================

# decoder_3to8_reg

3-to-8 one-hot decoder with enable that turns the 3-bit register fields of an instruction (Rx = Instrucao[5:3], Ry = Instrucao[2:0]) into the per-register select vectors Rin/Rout for R0..R7. The control unit instantiates it twice, once per field, with enable tied high. A combinational output serves same-cycle control decode. A registered copy, cleared by synchronous reset, serves pipelined consumers.

## Interface
Parameters:
- N, default 3: select width. Output width is 2**N. Legal range 1..4.
- REVERSE, default 0: bit order. 0 means W=k drives Y[k]. 1 means W=k drives Y[2**N-1-k].

Ports:
- Clock  in  1: single clock, rising edge. Used only by the registered output.
- Resetn  in  1: reset, synchronous and active-high. The name follows the codebase convention; the polarity is active-high regardless of the suffix.
- W  in  N: field to decode (instruction bits XXX or YYY).
- En  in  1: decoder enable. The control unit ties it to 1.
- Y  out  2**N: combinational one-hot decode.
- Yq  out  2**N: registered decode.

## Operation
- En=1: exactly one bit of Y is 1, at position W (or the mirrored position when REVERSE=1). All other bits are 0.
- En=0: Y is all zeros.
- W containing X or Z:
  - Y is all zeros in synthesis semantics.
  - Simulation must not produce more than one hot bit.
- Y is purely combinational from W and En. It has no dependence on Clock or Resetn.
- Yq is loaded with Y on every rising Clock edge when Resetn=0.
- Resetn=1 at a rising edge forces Yq to 0. Reset wins over any simultaneous W/En change.
- No internal state besides Yq. No handshake.

## Timing
- Y latency: 0 cycles. Settles within the same cycle W/En change. The control unit relies on this to assert Rin/Rout in step T1.
- Yq latency: 1 cycle. Yq at edge k+1 equals Y sampled at edge k.
- Reset values:
  - Yq = 0 after the first edge with Resetn=1.
  - Yq is undefined (X allowed) before any reset edge.
  - Y is unaffected by reset.
- Reset asserted mid-operation: Yq clears at the next edge. Y keeps decoding.
- Deassertion: the first edge with Resetn=0 loads the current Y.
- Boundaries:
  - W=0 and W=2**N-1 must hit the extreme bits Y[0] and Y[2**N-1] (swapped when REVERSE=1).
  - No wrap-around: every W value maps to a distinct bit.

## Structure
- A shared package holds the constants REG_SEL_W=3 and NUM_REGS=8, plus a typedef reg_onehot_t (8-bit one-hot). The control unit and the register file use the same ones.
- One sub-module is natural: decoder_comb (pure combinational N-to-2**N decode with enable). This block wraps it and adds the Yq register.
- The control unit instantiates two copies: Rx drives Rin, Ry drives Rout.

## Test plan
- Exhaustive sweep, En=1, REVERSE=0: W=0..7 gives Y = 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80. Same-cycle check; exactly one bit set each time.
- Enable gating: En=0 for all W in 0..7 gives Y=0x00. Toggling En 0 to 1 with W=5 gives Y=0x20 immediately.
- Reverse order: REVERSE=1, W=0 gives Y=0x80; W=7 gives Y=0x01; W=3 gives Y=0x10.
- Registered path:
  - Resetn=1 for one edge gives Yq=0x00.
  - Release, hold W=2 and En=1: Yq=0x04 at the next edge.
  - Change W to 6: Yq=0x40 one edge later, while Y=0x40 already in the same cycle.
- Reset collision: W=4, En=1, Resetn=1 at the same edge gives Yq=0x00, with Y=0x10 throughout. Release Resetn: Yq=0x10 at the following edge.
- Instruction fields: Instrucao=9'b000_011_101 (mv R3,R5) on two instances gives Rx decode Y=0x08 and Ry decode Y=0x20.

Source files
------------

// File: rtl/decoder_3to8_reg_pkg.sv
// Constants and types shared by the control unit, the register file and the
// register-select decoders.
package decoder_3to8_reg_pkg;

    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;

    typedef logic [NUM_REGS-1:0] reg_onehot_t;

    // Bit position driven by select value k, optionally mirrored end-for-end.
    function automatic int unsigned onehot_pos(input int unsigned k,
                                               input int unsigned width,
                                               input bit          reverse);
        return reverse ? (width - 1 - k) : k;
    endfunction

endpackage

// File: rtl/decoder_3to8_reg_comb.sv
// Pure combinational N-to-2**N one-hot decoder with enable; an unknown select
// compares false everywhere, so at most one bit can ever be hot.
module decoder_comb
    import decoder_3to8_reg_pkg::*;
#(
    parameter int N       = 3,
    parameter bit REVERSE = 1'b0
) (
    input  logic [N-1:0]    w,
    input  logic            en,
    output logic [2**N-1:0] y
);

    localparam int OUT_W = 2**N;

    always_comb begin
        y = '0;
        if (en) begin
            for (int k = 0; k < OUT_W; k++) begin
                if (w == N'(k)) begin
                    y[onehot_pos(k, OUT_W, REVERSE)] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/decoder_3to8_reg.sv
// Register-field decoder: same-cycle one-hot select Y plus a registered copy
// Yq for pipelined consumers, cleared by a synchronous active-high reset.
module decoder_3to8_reg
    import decoder_3to8_reg_pkg::*;
#(
    parameter int N       = REG_SEL_W,
    parameter bit REVERSE = 1'b0
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [N-1:0]    W,
    input  logic            En,
    output logic [2**N-1:0] Y,
    output logic [2**N-1:0] Yq
);

    decoder_comb #(
        .N       (N),
        .REVERSE (REVERSE)
    ) u_decoder_comb (
        .w  (W),
        .en (En),
        .y  (Y)
    );

    // Resetn is active-high despite its name; reset beats any load.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            Yq <= '0;
        end else begin
            Yq <= Y;
        end
    end

endmodule

// File: tb/tb_decoder_3to8_reg.sv
// Directed self-checking bench for decoder_3to8_reg: forward, reversed and
// instruction-field instances sharing one clock.
module tb_decoder_3to8_reg;
    import decoder_3to8_reg_pkg::*;

    logic                 clock;
    logic                 resetn;
    logic [REG_SEL_W-1:0] w_rx, w_ry, w_rev;
    logic                 en;
    reg_onehot_t          y_rx, yq_rx, y_ry, yq_ry, y_rev, yq_rev;

    int checks = 0;
    int errors = 0;

    decoder_3to8_reg #(.N(REG_SEL_W), .REVERSE(1'b0)) dut_rx (
        .Clock(clock), .Resetn(resetn), .W(w_rx), .En(en), .Y(y_rx), .Yq(yq_rx)
    );

    decoder_3to8_reg #(.N(REG_SEL_W), .REVERSE(1'b0)) dut_ry (
        .Clock(clock), .Resetn(resetn), .W(w_ry), .En(1'b1), .Y(y_ry), .Yq(yq_ry)
    );

    decoder_3to8_reg #(.N(REG_SEL_W), .REVERSE(1'b1)) dut_rev (
        .Clock(clock), .Resetn(resetn), .W(w_rev), .En(1'b1), .Y(y_rev), .Yq(yq_rev)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic check_output(input string tag, input reg_onehot_t observed,
                                input reg_onehot_t expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [REG_SEL_W-1:0] w_val, input logic en_val,
                                  input logic rst_val);
        w_rx   = w_val;
        en     = en_val;
        resetn = rst_val;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    reg_onehot_t fwd_table [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [8:0]  instrucao;

    initial begin
        w_ry  = '0;
        w_rev = '0;
        apply_stimulus(3'd0, 1'b1, 1'b1);
        tick();
        check_output("reset_yq_rx", yq_rx, 8'h00);
        check_output("reset_yq_rev", yq_rev, 8'h00);

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(3'(k), 1'b1, 1'b1);
            check_output($sformatf("sweep_w%0d", k), y_rx, fwd_table[k]);
        end

        for (int k = 0; k < 8; k++) begin
            apply_stimulus(3'(k), 1'b0, 1'b1);
            check_output($sformatf("disabled_w%0d", k), y_rx, 8'h00);
        end
        apply_stimulus(3'd5, 1'b1, 1'b1);
        check_output("enable_rise_w5", y_rx, 8'h20);

        w_rev = 3'd0; #1;
        check_output("reverse_w0", y_rev, 8'h80);
        w_rev = 3'd7; #1;
        check_output("reverse_w7", y_rev, 8'h01);
        w_rev = 3'd3; #1;
        check_output("reverse_w3", y_rev, 8'h10);

        apply_stimulus(3'd2, 1'b1, 1'b1);
        tick();
        check_output("reg_reset", yq_rx, 8'h00);
        apply_stimulus(3'd2, 1'b1, 1'b0);
        check_output("reg_release_hold", yq_rx, 8'h00);
        tick();
        check_output("reg_load_w2", yq_rx, 8'h04);
        apply_stimulus(3'd6, 1'b1, 1'b0);
        check_output("comb_w6_same_cycle", y_rx, 8'h40);
        check_output("reg_w6_not_yet", yq_rx, 8'h04);
        tick();
        check_output("reg_load_w6", yq_rx, 8'h40);
        check_output("reg_reverse_w3", yq_rev, 8'h10);

        apply_stimulus(3'd4, 1'b1, 1'b1);
        check_output("collision_y_before", y_rx, 8'h10);
        tick();
        check_output("collision_yq", yq_rx, 8'h00);
        check_output("collision_y_after", y_rx, 8'h10);
        apply_stimulus(3'd4, 1'b1, 1'b0);
        tick();
        check_output("collision_release", yq_rx, 8'h10);

        instrucao = 9'b000_011_101;
        apply_stimulus(instrucao[5:3], 1'b1, 1'b0);
        w_ry = instrucao[2:0];
        #1;
        check_output("instr_rx_rin", y_rx, 8'h08);
        check_output("instr_ry_rout", y_ry, 8'h20);
        tick();
        check_output("instr_ry_reg", yq_ry, 8'h20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
